// File: rtl/vmicro16_uart_rx_apb.sv
// vmicro16_uart_rx_apb
//   8N1 UART receiver with an APB3 read-only register window and a receive FIFO.
//   The line is resynchronised and the start bit is checked at mid-bit.
//   Each data bit and the stop bit are then sampled one bit time apart.
//   Good frames are pushed into the FIFO. Frame and overrun errors are sticky
//   flags that are cleared by reading STATUS.
//
// Ports
//   clk, reset   : system clock, synchronous active-high reset
//   rxd          : asynchronous serial input, idle high
//   S_P*         : APB3 slave, zero wait states, PADDR[1:0] decoded
//                  0 DATA   (read pops FIFO head, 0 when empty)
//                  1 STATUS ([0] not empty, [1] full, [2] overrun, [3] frame_err)
//                  2,3      read 0
//   rx_irq       : high while the FIFO holds data
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for a falling edge on the synchronised line
// S_START | timing to mid start bit, rejecting glitches
// S_DATA  | sampling 8 data bits LSB first, one per bit time
// S_STOP  | sampling stop bit; push byte or flag a frame error
module vmicro16_uart_rx_apb #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxd,
    input  logic [15:0]           S_PADDR,
    input  logic                  S_PWRITE,
    input  logic                  S_PSELx,
    input  logic                  S_PENABLE,
    input  logic [DATA_WIDTH-1:0] S_PWDATA,
    output logic [DATA_WIDTH-1:0] S_PRDATA,
    output logic                  S_PREADY,
    output logic                  rx_irq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH   = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          rx_m_q, rx_s_q, rx_prev_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_q, push_d;
    logic          frame_set;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d, frame_err_q, frame_err_d;

    logic rd_access, pop, stat_clr, empty, full, do_push, ovr_set;

    // Upper address bits and write data are intentionally not decoded.
    logic unused_apb;
    assign unused_apb = ^{S_PADDR[15:2], S_PWDATA};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_TC) begin
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_TC) begin
                    shift_d[bit_idx_q] = rx_s_q;
                    cnt_d              = '0;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == BIT_TC) begin
                    // The byte stays in shift_q until the next frame's first
                    // data sample, so the delayed push can read it directly.
                    if (rx_s_q) push_d    = 1'b1;
                    else        frame_set = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    assign rd_access = S_PSELx & S_PENABLE & ~S_PWRITE;
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH);
    assign pop       = rd_access && (S_PADDR[1:0] == 2'd0) && !empty;
    assign stat_clr  = rd_access && (S_PADDR[1:0] == 2'd1);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push   = push_q && (!full || pop);
    assign ovr_set   = push_q && full && !pop;

    always_comb begin
        wr_ptr_d    = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q;
        if (do_push && !pop) count_d = count_q + 1'b1;
        if (!do_push && pop) count_d = count_q - 1'b1;
        // A set in the clearing cycle wins over the clear.
        overrun_d   = ovr_set   | (overrun_q   & ~stat_clr);
        frame_err_d = frame_set | (frame_err_q & ~stat_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m_q      <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_m_q      <= rxd;
            rx_s_q      <= rx_m_q;
            rx_prev_q   <= rx_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= shift_q;
    end

    always_comb begin
        S_PRDATA = '0;
        if (rd_access) begin
            case (S_PADDR[1:0])
                2'd0:    if (!empty) S_PRDATA = DATA_WIDTH'(mem[rd_ptr_q]);
                2'd1:    S_PRDATA = DATA_WIDTH'({frame_err_q, overrun_q, full, !empty});
                default: S_PRDATA = '0;
            endcase
        end
    end

    assign S_PREADY = 1'b1;
    assign rx_irq   = !empty;

endmodule
